// File: rtl/exec_sequencer.sv
// ============================================================================
// exec_sequencer
//
// Multi-cycle control sequencer for the decode/execute datapath. It owns the
// PC, fetches one instruction at a time over a req/ack memory handshake,
// issues it to the execute unit, waits for completion, then commits the
// register-file write and advances or redirects the PC.
//
// Instruction flow: FETCH (>=1) -> DECODE (1) -> EXECUTE (>=1) -> WRITEBACK (1)
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start, stop           control pulses (begin at RESET_PC / stop at boundary)
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr = pc)
//   instr_valid           one-cycle issue strobe in the first EXECUTE cycle
//   instruction           registered instruction (IR)
//   exec_done/result/wr_en/branch_taken/branch_target
//                         completion bundle from the execute unit
//   rf_we/waddr/wdata     register-file write port, active in WRITEBACK
//   pc, busy, halted, error, instr_count   status
//
// Every output is either a register or decoded purely from registers, so
// there is no combinational path from any input to any output.
// ============================================================================
module exec_sequencer #(
    parameter int unsigned     AW           = 16,
    parameter logic [AW-1:0]   RESET_PC     = '0,
    parameter logic [6:0]      HALT_OPCODE  = 7'h7F,
    parameter int unsigned     EXEC_TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    output logic [31:0]   instruction,
    input  logic          exec_done,
    input  logic [31:0]   exec_result,
    input  logic          exec_wr_en,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    output logic          rf_we,
    output logic [4:0]    rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          error,
    output logic [31:0]   instr_count
);

    // The timeout counter only ever holds 0 .. EXEC_TIMEOUT-1.
    localparam int unsigned    CW       = (EXEC_TIMEOUT > 2) ? $clog2(EXEC_TIMEOUT) : 1;
    localparam logic [CW-1:0]  TMO_LAST = CW'(EXEC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [AW-1:0]   pc_q;
    logic [31:0]     ir_q;
    logic [31:0]     result_q;
    logic            wr_en_q;
    logic            branch_q;
    logic [AW-1:0]   target_q;
    logic [CW-1:0]   tmo_cnt;
    logic            instr_valid_q;
    logic            stop_pending;
    logic [31:0]     instr_count_q;

    logic            is_halt;
    logic            target_misaligned;
    logic            exec_timed_out;

    assign is_halt           = (ir_q[6:0] == HALT_OPCODE);
    assign target_misaligned = branch_q && (target_q[1:0] != 2'b00);
    assign exec_timed_out    = !exec_done && (tmo_cnt == TMO_LAST);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is always written with non-blocking (<=) so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaulting state_n before the case keeps every path assigned,
        // so no latch is inferred.
        state_n = state;
        case (state)
            S_IDLE, S_HALTED, S_ERROR: begin
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) state_n = S_DECODE;
            end
            S_DECODE: begin
                state_n = is_halt ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (exec_done)           state_n = S_WRITEBACK;
                else if (exec_timed_out) state_n = S_ERROR;
            end
            S_WRITEBACK: begin
                // A stop arriving in the writeback cycle itself still lands on
                // this instruction boundary.
                if (target_misaligned)          state_n = S_ERROR;
                else if (stop_pending || stop)  state_n = S_IDLE;
                else                            state_n = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers: PC, IR, captured execute bundle, counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            result_q      <= '0;
            wr_en_q       <= 1'b0;
            branch_q      <= 1'b0;
            target_q      <= '0;
            tmo_cnt       <= '0;
            instr_valid_q <= 1'b0;
            stop_pending  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            instr_valid_q <= 1'b0;

            case (state)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (start) begin
                        pc_q          <= RESET_PC;
                        instr_count_q <= '0;
                        stop_pending  <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (stop)     stop_pending <= 1'b1;
                    if (imem_ack) ir_q         <= imem_rdata;
                end

                S_DECODE: begin
                    tmo_cnt <= '0;
                    if (is_halt) begin
                        // Halting consumes any outstanding stop request.
                        stop_pending <= 1'b0;
                    end else begin
                        instr_valid_q <= 1'b1;
                        if (stop) stop_pending <= 1'b1;
                    end
                end

                S_EXECUTE: begin
                    tmo_cnt <= tmo_cnt + CW'(1);
                    if (exec_done) begin
                        result_q <= exec_result;
                        wr_en_q  <= exec_wr_en;
                        branch_q <= branch_taken;
                        target_q <= branch_target;
                    end
                    if (exec_timed_out) begin
                        stop_pending <= 1'b0;
                    end else if (stop) begin
                        stop_pending <= 1'b1;
                    end
                end

                S_WRITEBACK: begin
                    // Every exit from writeback either honours the stop or
                    // lands in ERROR, so the request is consumed here.
                    stop_pending <= 1'b0;
                    if (instr_count_q != '1) begin
                        instr_count_q <= instr_count_q + 32'd1;
                    end
                    if (!branch_q) begin
                        pc_q <= pc_q + AW'(4);
                    end else if (!target_misaligned) begin
                        pc_q <= target_q;
                    end
                end

                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (registers or pure state decodes)
    // ------------------------------------------------------------------------
    assign imem_req    = (state == S_FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instruction = ir_q;

    assign rf_we       = (state == S_WRITEBACK) && wr_en_q && (ir_q[11:7] != 5'd0);
    assign rf_waddr    = ir_q[11:7];
    assign rf_wdata    = result_q;

    assign pc          = pc_q;
    assign busy        = (state == S_FETCH) || (state == S_DECODE) ||
                         (state == S_EXECUTE) || (state == S_WRITEBACK);
    assign halted      = (state == S_HALTED);
    assign error       = (state == S_ERROR);
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// ============================================================================
// tb_exec_sequencer
//
// Directed testbench for exec_sequencer. The stimulus process pushes the
// expected fetch addresses and register-file writes into queues; a monitor
// on the falling edge pops and compares whenever the DUT starts a fetch or
// pulses rf_we. Status outputs are checked directly by the stimulus process.
// ============================================================================
module tb_exec_sequencer;

    localparam int unsigned AW  = 16;
    localparam int unsigned TMO = 64;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          stop;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instruction;
    logic          exec_done;
    logic [31:0]   exec_result;
    logic          exec_wr_en;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;
    logic          error;
    logic [31:0]   instr_count;

    int            tests = 0;
    int            fails = 0;

    logic [AW-1:0] fetch_q[$];
    wb_t           wb_q[$];
    logic [31:0]   cur_instr;

    exec_sequencer #(
        .AW           (AW),
        .RESET_PC     (16'h0000),
        .HALT_OPCODE  (7'h7F),
        .EXEC_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .exec_done     (exec_done),
        .exec_result   (exec_result),
        .exec_wr_en    (exec_wr_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .error         (error),
        .instr_count   (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there
    // (after the edge has settled) or on the falling edge by the monitor.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: fetch starts and register-file writes against the scoreboard
    // ------------------------------------------------------------------------
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (imem_req && !prev_req) begin
                if (fetch_q.size() == 0) begin
                    check("fetch_expected", 64'(fetch_q.size() != 0), 64'd1);
                end else begin
                    check("fetch_addr", 64'(imem_addr), 64'(fetch_q.pop_front()));
                end
            end
            prev_req = imem_req;

            if (rf_we) begin
                if (wb_q.size() == 0) begin
                    check("rf_we_expected", 64'(wb_q.size() != 0), 64'd1);
                end else begin
                    wb_t exp_wb;
                    exp_wb = wb_q.pop_front();
                    check("rf_waddr", 64'(rf_waddr), 64'(exp_wb.addr));
                    check("rf_wdata", 64'(rf_wdata), 64'(exp_wb.data));
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic pulse_start(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Serve one fetch at exp_addr after wait_n stall cycles; ends in DECODE.
    task automatic do_fetch(input logic [31:0] data, input int wait_n, input logic [AW-1:0] exp_addr);
        int n;
        fetch_q.push_back(exp_addr);
        cur_instr = data;
        n = 0;
        while (!imem_req && n < 8) begin
            tick();
            n++;
        end
        check("fetch_req", 64'(imem_req), 64'd1);
        for (int i = 0; i < wait_n; i++) begin
            check("fetch_hold_req", 64'(imem_req), 64'd1);
            check("fetch_hold_addr", 64'(imem_addr), 64'(exp_addr));
            tick();
        end
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h5A5A_0F0F;
        check("fetch_req_drop", 64'(imem_req), 64'd0);
    endtask

    // Complete one execute after delay cycles; ends in WRITEBACK.
    task automatic do_exec(input int delay, input logic [31:0] res, input logic wr,
                           input logic br, input logic [AW-1:0] tgt, input logic stop_it);
        int n;
        n = 0;
        while (!instr_valid && n < 8) begin
            tick();
            n++;
        end
        check("instr_valid", 64'(instr_valid), 64'd1);
        stop = stop_it;
        for (int i = 0; i < delay; i++) begin
            tick();
            stop = 1'b0;
            if (i == 0) check("instr_valid_one_cycle", 64'(instr_valid), 64'd0);
        end
        exec_done     = 1'b1;
        exec_result   = res;
        exec_wr_en    = wr;
        branch_taken  = br;
        branch_target = tgt;
        if (wr && cur_instr[11:7] != 5'd0) wb_q.push_back('{addr: cur_instr[11:7], data: res});
        tick();
        stop          = 1'b0;
        exec_done     = 1'b0;
        exec_wr_en    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0FFC;
        exec_result   = 32'h1357_9BDF;
        if (delay == 0) check("instr_valid_one_cycle", 64'(instr_valid), 64'd0);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        exec_done = 1'b0; exec_result = '0; exec_wr_en = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        cur_instr = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pc", 64'(pc), 64'h0000);
        check("rst_count", 64'(instr_count), 64'd0);
        check("rst_halted_error", 64'({halted, error}), 64'd0);
        check("rst_strobes", 64'({imem_req, instr_valid, rf_we}), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_req", 64'(imem_req), 64'd0);

        // First instruction: zero-wait ack, done with the issue strobe
        pulse_start(1'b0);
        check("start_busy", 64'(busy), 64'd1);
        do_fetch(32'h0000_0113, 0, 16'h0000);
        check("ir_loaded", 64'(instruction), 64'h0000_0113);
        check("decode_no_issue", 64'(instr_valid), 64'd0);
        tick();
        check("issue_4th_cycle", 64'(instr_valid), 64'd1);
        do_exec(0, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("pc_plus4", 64'(pc), 64'h0004);
        check("count_1", 64'(instr_count), 64'd1);

        // rd = 0 with wr_en: no write, pc still advances
        do_fetch(32'h0000_0033, 0, 16'h0004);
        do_exec(2, 32'h0000_1234, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("rd0_pc", 64'(pc), 64'h0008);
        check("count_2", 64'(instr_count), 64'd2);

        // Taken branch to 0x0040
        do_fetch(32'h0000_0193, 0, 16'h0008);
        do_exec(1, 32'hCAFE_F00D, 1'b1, 1'b1, 16'h0040, 1'b0);
        tick();
        check("branch_pc", 64'(pc), 64'h0040);

        // Stalled fetch, then stop during EXECUTE
        do_fetch(32'h0000_0213, 5, 16'h0040);
        do_exec(2, 32'h0BAD_F00D, 1'b1, 1'b0, '0, 1'b1);
        tick();
        check("stop_idle_busy", 64'(busy), 64'd0);
        check("stop_pc", 64'(pc), 64'h0044);
        check("count_4", 64'(instr_count), 64'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stop_no_fetch", 64'(imem_req), 64'd0);
        end

        // start+stop together in IDLE: start wins, stop must not stick
        pulse_start(1'b1);
        check("restart_count", 64'(instr_count), 64'd0);
        do_fetch(32'h0000_0113, 0, 16'h0000);
        do_exec(0, 32'h0000_0001, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("stop_ignored_busy", 64'(busy), 64'd1);

        // Halt instruction
        do_fetch(32'h0000_007F, 0, 16'h0004);
        check("halt_decode_no_issue", 64'(instr_valid), 64'd0);
        tick();
        check("halted", 64'(halted), 64'd1);
        check("halt_busy", 64'(busy), 64'd0);
        check("halt_pc", 64'(pc), 64'h0004);
        check("halt_count", 64'(instr_count), 64'd1);
        check("halt_no_issue", 64'(instr_valid), 64'd0);

        // start out of HALTED resumes at RESET_PC
        pulse_start(1'b0);
        check("unhalt", 64'({halted, busy}), 64'b01);
        do_fetch(32'h0000_0293, 0, 16'h0000);
        do_exec(0, 32'h0000_0055, 1'b1, 1'b0, '0, 1'b0);
        tick();
        check("resume_pc", 64'(pc), 64'h0004);
        check("resume_count", 64'(instr_count), 64'd1);

        // Execute timeout
        do_fetch(32'h0000_0313, 0, 16'h0004);
        n = 0;
        while (!instr_valid && n < 8) begin
            tick();
            n++;
        end
        check("tmo_issue", 64'(instr_valid), 64'd1);
        repeat (TMO - 1) tick();
        check("tmo_not_yet", 64'({error, busy}), 64'b01);
        tick();
        check("tmo_error", 64'({error, busy}), 64'b10);
        check("tmo_pc", 64'(pc), 64'h0004);
        exec_done = 1'b1; exec_wr_en = 1'b1; exec_result = 32'hFFFF_0000;
        tick();
        exec_done = 1'b0; exec_wr_en = 1'b0;
        tick();
        check("late_done_ignored", 64'(error), 64'd1);

        // start out of ERROR, then a misaligned branch target
        pulse_start(1'b0);
        check("clear_error", 64'({error, busy}), 64'b01);
        do_fetch(32'h0000_0393, 0, 16'h0000);
        do_exec(1, 32'hA5A5_A5A5, 1'b1, 1'b1, 16'h0042, 1'b0);
        tick();
        check("misalign_error", 64'({error, busy}), 64'b10);
        check("misalign_pc_held", 64'(pc), 64'h0000);

        // Reset in the middle of EXECUTE with a non-reset pc
        pulse_start(1'b0);
        do_fetch(32'h0000_0113, 0, 16'h0000);
        do_exec(0, 32'h0000_0001, 1'b1, 1'b0, '0, 1'b0);
        tick();
        do_fetch(32'h0000_0193, 0, 16'h0004);
        tick(); tick();
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pc", 64'(pc), 64'h0000);
        check("mid_rst_rf_we", 64'(rf_we), 64'd0);
        check("mid_rst_count", 64'(instr_count), 64'd0);
        check("mid_rst_ir", 64'(instruction), 64'd0);
        check("mid_rst_wdata", 64'(rf_wdata), 64'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", 64'({imem_req, busy}), 64'd0);

        check("fetch_q_drained", 64'(fetch_q.size()), 64'd0);
        check("wb_q_drained", 64'(wb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle control sequencer for the decode/execute datapath. Owns the PC and fetches instructions over a req/ack memory handshake. Issues each instruction to the execute unit, waits for completion, commits the register-file write and advances or redirects the PC. Sits between instruction memory, the decode/execute unit and the register-file write port.

Parameters:
AW, 16, PC / instruction-memory byte-address width
RESET_PC, 0, PC loaded on start (AW bits, word aligned)
HALT_OPCODE, 7'h7F, value of instruction[6:0] that halts the core
EXEC_TIMEOUT, 64, max cycles in EXECUTE before error (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
start  in  1  pulse: begin execution at RESET_PC
stop  in  1  pulse: request stop at next instruction boundary
imem_req  out  1  fetch request
imem_addr  out  AW  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
instr_valid  out  1  one-cycle issue strobe to execute unit
instruction  out  32  registered instruction (IR)
exec_done  in  1  execute unit completion strobe
exec_result  in  32  result, valid with exec_done
exec_wr_en  in  1  instruction writes rd, valid with exec_done
branch_taken  in  1  redirect PC, valid with exec_done
branch_target  in  AW  redirect address, valid with exec_done
rf_we  out  1  register-file write enable
rf_waddr  out  5  destination register (IR[11:7])
rf_wdata  out  32  write data
pc  out  AW  current PC
busy  out  1  state not IDLE/HALTED/ERROR
halted  out  1  state == HALTED
error  out  1  state == ERROR
instr_count  out  32  retired instructions, saturating at 32'hFFFFFFFF

Behaviour:
- Reset (async, any state): state=IDLE; pc=RESET_PC; IR, rf_wdata, instr_count=0; all strobes, busy, halted, error and stop_pending=0.
- All outputs registered or decoded from state; no combinational input-to-output path.
- IDLE: start -> pc<=RESET_PC, instr_count<=0, -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, both stable until imem_ack. imem_ack is ignored when imem_req=0. On ack: IR<=imem_rdata -> DECODE. imem_req is low in the following cycle.
- DECODE (1 cycle): IR[6:0]==HALT_OPCODE -> HALTED (pc unchanged, not counted). Otherwise -> EXECUTE, instr_valid=1 in the first EXECUTE cycle only.
- EXECUTE: timeout counter starts at 0 on entry. On exec_done: capture result, wr_en, branch_taken and target -> WRITEBACK. exec_done in the entry cycle is accepted (minimum 1 cycle). Counter reaching EXEC_TIMEOUT without done -> ERROR.
- WRITEBACK (1 cycle): rf_we=1 iff captured wr_en && IR[11:7]!=0; rf_waddr=IR[11:7]; rf_wdata=result.
  - pc<=branch ? target : pc+4; pc+4 wraps modulo 2^AW.
  - Branch target with [1:0]!=0 -> ERROR with rf_we still performed, pc not updated.
  - instr_count increments, saturating.
  - Next state: stop_pending -> IDLE (clear stop_pending); else -> FETCH.
- Instruction latency: FETCH(>=1) + DECODE(1) + EXECUTE(>=1) + WRITEBACK(1); minimum 4 cycles with zero-wait ack/done.
- stop: sets stop_pending in FETCH/DECODE/EXECUTE/WRITEBACK; ignored elsewhere. Stop in DECODE of a halt instruction -> HALTED, pending cleared.
- start while busy: ignored. start in HALTED or ERROR: same as IDLE start (clears error/halted).
- start and stop in the same cycle in IDLE: start wins, stop ignored.
- exec_done outside EXECUTE and imem_ack outside FETCH: ignored.

Test Plan:
- Reset mid-EXECUTE (exec_done never returned) -> next cycle state IDLE, pc=RESET_PC, rf_we=0, instr_count=0, busy=0.
- start; mem returns 32'h00000113 with 0-wait ack; exec_done same cycle as instr_valid, exec_wr_en=1, result 32'hDEADBEEF -> rf_we pulse with waddr=2, wdata=DEADBEEF; pc=4; instr_valid 4 cycles after start; instr_count=1.
- Instruction with rd=0 and exec_wr_en=1 -> rf_we stays 0, pc advances by 4; branch_taken=1, target 16'h0040 -> next imem_addr=0x0040.
- imem_ack delayed 5 cycles -> imem_req/imem_addr stable all 5 cycles; stop pulsed during EXECUTE -> writeback completes, then IDLE, no further imem_req.
- Instruction 32'h0000007F fetched -> halted=1, pc unchanged, instr_count unchanged; start -> fetch resumes at RESET_PC.
- exec_done withheld for EXEC_TIMEOUT cycles -> error=1, busy=0. Separately, branch target 16'h0042 -> error=1, pc held.
